// File: rtl/fft8_butterfly_scheduler.sv
// Butterfly issue sequencer for an 8-point radix-2 DIT FFT: 3 stages x 4 butterflies, one per cycle.
// Latency: first issue 1 cycle after START; write-back trails issue by MAC_LATENCY; DONE 3*(4+L)+1 cycles after START.
// Backpressure: none by default; with FFT_SCHED_STALL_EN defined, STALL freezes issue while in-flight writes drain.
module fft8_butterfly_scheduler #(
    parameter int MAC_LATENCY = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
`ifdef FFT_SCHED_STALL_EN
    input  logic       STALL,
`endif
    output logic       BUSY,
    output logic       DONE,
    output logic [1:0] STAGE,
    output logic       RD_En,
    output logic [2:0] RD_Addr0,
    output logic [2:0] RD_Addr1,
    output logic [1:0] W8_Index,
    output logic       WR_En,
    output logic [2:0] WR_Addr0,
    output logic [2:0] WR_Addr1
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam logic [2:0] DRAIN_LAST = 3'(MAC_LATENCY - 1);

    state_t     state, state_nxt;
    logic [1:0] stage_q, stage_nxt;
    logic [1:0] bfly_q, bfly_nxt;
    logic [2:0] drain_q, drain_nxt;
    logic       hold;

    logic [2:0] span, k3, a_lo, a_base, addr_a, addr_b;
    logic [1:0] w_lo, w_idx;

    logic [6:0] wr_pipe [MAC_LATENCY];

`ifdef FFT_SCHED_STALL_EN
    assign hold = (state == ISSUE) && STALL;
`else
    assign hold = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= IDLE;
            stage_q <= 2'd0;
            bfly_q  <= 2'd0;
            drain_q <= 3'd0;
        end else begin
            state   <= state_nxt;
            stage_q <= stage_nxt;
            bfly_q  <= bfly_nxt;
            drain_q <= drain_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stage_nxt = stage_q;
        bfly_nxt  = bfly_q;
        drain_nxt = drain_q;
        case (state)
            IDLE: begin
                if (START) begin
                    state_nxt = ISSUE;
                    stage_nxt = 2'd0;
                    bfly_nxt  = 2'd0;
                end
            end
            ISSUE: begin
                if (!hold) begin
                    if (bfly_q == 2'd3) begin
                        state_nxt = DRAIN;
                        bfly_nxt  = 2'd0;
                        drain_nxt = 3'd0;
                    end else begin
                        bfly_nxt = bfly_q + 2'd1;
                    end
                end
            end
            DRAIN: begin
                // Next stage reads what this stage wrote, so wait for the MAC pipe to empty.
                if (drain_q == DRAIN_LAST) begin
                    drain_nxt = 3'd0;
                    if (stage_q == 2'd2) begin
                        state_nxt = FIN;
                    end else begin
                        state_nxt = ISSUE;
                        stage_nxt = stage_q + 2'd1;
                        bfly_nxt  = 2'd0;
                    end
                end else begin
                    drain_nxt = drain_q + 3'd1;
                end
            end
            FIN: begin
                state_nxt = IDLE;
                stage_nxt = 2'd0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // DIT addressing: span = 2^s, upper = (k>>s)*2*span + (k mod span), lower = upper + span.
    always_comb begin
        k3     = {1'b0, bfly_q};
        span   = 3'd1 << stage_q;
        a_lo   = k3 & (span - 3'd1);
        a_base = (k3 >> stage_q) << (stage_q + 2'd1);
        addr_a = a_base + a_lo;
        addr_b = addr_a + span;
        w_lo   = a_lo[1:0];
        w_idx  = w_lo << (2'd2 - stage_q);
    end

    always_comb begin
        BUSY     = (state == ISSUE) || (state == DRAIN);
        DONE     = (state == FIN);
        STAGE    = BUSY ? stage_q : 2'd0;
        RD_En    = (state == ISSUE) && !hold;
        RD_Addr0 = RD_En ? addr_a : 3'd0;
        RD_Addr1 = RD_En ? addr_b : 3'd0;
        W8_Index = RD_En ? w_idx : 2'd0;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < MAC_LATENCY; i++) wr_pipe[i] <= 7'd0;
        end else begin
            wr_pipe[0] <= {RD_En, RD_Addr0, RD_Addr1};
            for (int i = 1; i < MAC_LATENCY; i++) wr_pipe[i] <= wr_pipe[i-1];
        end
    end

    assign {WR_En, WR_Addr0, WR_Addr1} = wr_pipe[MAC_LATENCY-1];

endmodule

// File: tb/tb_fft8_butterfly_scheduler.sv
// Directed bench: L=2 schedule table, held START, async abort, L=1 timing, optional STALL sequence.
module tb_fft8_butterfly_scheduler;

    logic       clk, rst_n, start, stall;
    logic       busy, done, rd_en, wr_en;
    logic [1:0] stage, w8;
    logic [2:0] rd_a0, rd_a1, wr_a0, wr_a1;
    logic       b1_busy, b1_done, b1_rd_en, b1_wr_en;
    logic [1:0] b1_stage, b1_w8;
    logic [2:0] b1_rd_a0, b1_rd_a1, b1_wr_a0, b1_wr_a1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         t;
        logic [2:0] a0;
        logic [2:0] a1;
        logic [1:0] w;
    } iss_t;

    iss_t iss [12];

    fft8_butterfly_scheduler #(.MAC_LATENCY(2)) dut (
        .CLK(clk), .RST(rst_n), .START(start),
`ifdef FFT_SCHED_STALL_EN
        .STALL(stall),
`endif
        .BUSY(busy), .DONE(done), .STAGE(stage), .RD_En(rd_en),
        .RD_Addr0(rd_a0), .RD_Addr1(rd_a1), .W8_Index(w8),
        .WR_En(wr_en), .WR_Addr0(wr_a0), .WR_Addr1(wr_a1)
    );

    fft8_butterfly_scheduler #(.MAC_LATENCY(1)) dut_l1 (
        .CLK(clk), .RST(rst_n), .START(start),
`ifdef FFT_SCHED_STALL_EN
        .STALL(stall),
`endif
        .BUSY(b1_busy), .DONE(b1_done), .STAGE(b1_stage), .RD_En(b1_rd_en),
        .RD_Addr0(b1_rd_a0), .RD_Addr1(b1_rd_a1), .W8_Index(b1_w8),
        .WR_En(b1_wr_en), .WR_Addr0(b1_wr_a0), .WR_Addr1(b1_wr_a1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    wire [19:0] got_vec = {busy, done, stage, rd_en, rd_a0, rd_a1, w8, wr_en, wr_a0, wr_a1};
    wire [19:0] got_l1  = {b1_busy, b1_done, b1_stage, b1_rd_en, b1_rd_a0, b1_rd_a1, b1_w8,
                           b1_wr_en, b1_wr_a0, b1_wr_a1};

    task automatic check(input string name, input int t, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0d got=%h expected=%h", name, t, got, exp);
        end
    endtask

    // Expected L=2 outputs at cycle t after a START sampled in cycle 0.
    function automatic logic [19:0] exp_vec(input int t);
        logic       e_busy, e_done, e_rd, e_wr;
        logic [1:0] e_stg, e_w;
        logic [2:0] e_a0, e_a1, e_b0, e_b1;
        e_busy = (t >= 1 && t <= 18);
        e_done = (t == 19);
        e_stg  = (t >= 7 && t <= 12) ? 2'd1 : (t >= 13 && t <= 18) ? 2'd2 : 2'd0;
        e_rd = 1'b0; e_a0 = 3'd0; e_a1 = 3'd0; e_w = 2'd0;
        e_wr = 1'b0; e_b0 = 3'd0; e_b1 = 3'd0;
        for (int i = 0; i < 12; i++) begin
            if (iss[i].t == t) begin
                e_rd = 1'b1; e_a0 = iss[i].a0; e_a1 = iss[i].a1; e_w = iss[i].w;
            end
            if (iss[i].t + 2 == t) begin
                e_wr = 1'b1; e_b0 = iss[i].a0; e_b1 = iss[i].a1;
            end
        end
        return {e_busy, e_done, e_stg, e_rd, e_a0, e_a1, e_w, e_wr, e_b0, e_b1};
    endfunction

    // L=1: issue windows 1-4, 6-9, 11-14; DONE at 16.
    function automatic logic [3:0] exp_l1(input int t);
        logic r, w;
        r = 1'b0; w = 1'b0;
        for (int s = 0; s < 3; s++) begin
            if (t >= 1 + 5*s && t <= 4 + 5*s) r = 1'b1;
            if (t >= 2 + 5*s && t <= 5 + 5*s) w = 1'b1;
        end
        return {(t >= 1 && t <= 15), (t == 16), r, w};
    endfunction

    task automatic run_check(input bit hold, input bit chk_l1);
        @(posedge clk); #1 start = 1'b1;
        for (int t = 0; t <= 20; t++) begin
            @(negedge clk);
            check("sched", t, got_vec, exp_vec(t));
            if (chk_l1) check("lat1", t, {b1_busy, b1_done, b1_rd_en, b1_wr_en}, exp_l1(t));
            @(posedge clk); #1 start = hold;
        end
    endtask

    initial begin
        int done_seen;
        iss[0]  = '{1,  3'd0, 3'd1, 2'd0};
        iss[1]  = '{2,  3'd2, 3'd3, 2'd0};
        iss[2]  = '{3,  3'd4, 3'd5, 2'd0};
        iss[3]  = '{4,  3'd6, 3'd7, 2'd0};
        iss[4]  = '{7,  3'd0, 3'd2, 2'd0};
        iss[5]  = '{8,  3'd1, 3'd3, 2'd2};
        iss[6]  = '{9,  3'd4, 3'd6, 2'd0};
        iss[7]  = '{10, 3'd5, 3'd7, 2'd2};
        iss[8]  = '{13, 3'd0, 3'd4, 2'd0};
        iss[9]  = '{14, 3'd1, 3'd5, 2'd1};
        iss[10] = '{15, 3'd2, 3'd6, 2'd2};
        iss[11] = '{16, 3'd3, 3'd7, 2'd3};

        rst_n = 1'b0; start = 1'b0; stall = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", 0, got_vec, 20'd0);
        check("reset_state_l1", 0, got_l1, 20'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Single START pulse, both latencies.
        run_check(1'b0, 1'b1);

        // START held: one run, then restart at t=21.
        repeat (2) @(posedge clk);
        run_check(1'b1, 1'b0);
        @(negedge clk);
        check("restart", 21, {busy, rd_en, rd_a0, rd_a1}, {1'b1, 1'b1, 3'd0, 3'd1});
        @(posedge clk); #1 start = 1'b0;
        repeat (30) @(posedge clk);

        // Async reset in the middle of stage 1.
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (7) @(posedge clk);
        #2 check("pre_abort", 8, got_vec, exp_vec(8));
        rst_n = 1'b0;
        #1 check("abort_async", 8, got_vec, 20'd0);
        check("abort_async_l1", 8, got_l1, 20'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        check("no_done_after_abort", 0, done_seen, 0);
        run_check(1'b0, 1'b0);

`ifdef FFT_SCHED_STALL_EN
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        for (int t = 0; t <= 22; t++) begin
            @(negedge clk);
            if (t == 3 || t == 4) check("stall_gap", t, {rd_en, busy}, {1'b0, 1'b1});
            if (t == 5) check("stall_reissue", t, {rd_en, rd_a0, rd_a1}, {1'b1, 3'd4, 3'd5});
            if (t == 6) check("stall_next", t, {rd_en, rd_a0, rd_a1}, {1'b1, 3'd6, 3'd7});
            if (t == 5) check("stall_bubble", t, wr_en, 1'b0);
            if (t == 7) check("stall_wr", t, {wr_en, wr_a0, wr_a1}, {1'b1, 3'd4, 3'd5});
            if (t == 20 || t == 21) check("stall_done", t, done, (t == 21));
            @(posedge clk);
            #1 start = 1'b0;
            stall = (t + 1 == 3) || (t + 1 == 4);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft8_butterfly_scheduler.md
Name: fft8_butterfly_scheduler

Overview:
- Sequences the 8-point radix-2 DIT FFT over the butterfly MAC datapath: 3 stages x 4 butterflies, one butterfly issued per cycle.
- Generates operand read addresses, the twiddle index (W8_Index) and delayed write-back addresses/enables matched to the MAC pipeline latency.
- Sits between the sample register file (loaded in bit-reversed order upstream) and the MAC unit; top-level control uses a START/BUSY/DONE handshake.

Parameters:
- MAC_LATENCY, 2, cycles from operands/W8_Index presented to MAC until OUT0/OUT1 valid; legal range 1..7.

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-low
- START  in  1  run request; sampled only in IDLE
- BUSY  out  1  high from first issue cycle through last write-back cycle
- DONE  out  1  one-cycle pulse after final write-back
- STAGE  out  2  current stage 0..2
- RD_En  out  1  operand read / MAC issue valid
- RD_Addr0  out  3  address of butterfly upper input (MAC IN0)
- RD_Addr1  out  3  address of butterfly lower input (MAC IN1)
- W8_Index  out  2  twiddle index to MAC
- WR_En  out  1  write-back valid for MAC OUT0/OUT1
- WR_Addr0  out  3  write address for OUT0 (= RD_Addr0 delayed MAC_LATENCY)
- WR_Addr1  out  3  write address for OUT1 (= RD_Addr1 delayed MAC_LATENCY)

Behaviour:
- Reset (RST=0, async): state IDLE; all outputs 0; stage/butterfly/drain counters 0; write-delay pipe cleared. Reset mid-run aborts immediately, no DONE.
- States: IDLE, ISSUE, DRAIN, FIN.
- IDLE: START=1 -> ISSUE, stage s=0, butterfly k=0. START otherwise ignored (incl. in ISSUE/DRAIN/FIN).
- ISSUE: RD_En=1, BUSY=1; k increments 0..3; after k=3 -> DRAIN.
- Addressing, span=2^s: A = (k>>s)*2*span + (k & (span-1)); B = A+span; W8_Index = (k & (span-1)) << (2-s).
- Resulting schedule: s0 (0,1)(2,3)(4,5)(6,7) W 0,0,0,0; s1 (0,2)(1,3)(4,6)(5,7) W 0,2,0,2; s2 (0,4)(1,5)(2,6)(3,7) W 0,1,2,3.
- DRAIN: RD_En=0 for exactly MAC_LATENCY cycles (read-after-write hazard between stages). Then s<2 -> ISSUE with s+1, k=0; s=2 -> FIN.
- FIN: DONE=1, BUSY=0 for one cycle -> IDLE.
- Write pipe: MAC_LATENCY-deep shift of {RD_En, RD_Addr0, RD_Addr1}; WR_En/WR_Addr* are its output. Last write of each stage lands on the final DRAIN cycle.
- Timing (START at t=0): stage s issues t = 1+s*(4+L) .. 4+s*(4+L); final WR_En at t = 3*(4+L); DONE at t = 3*(4+L)+1. With L=2: 18 and 19.
- STAGE holds s during ISSUE/DRAIN; 0 in IDLE/FIN.

Optional Feature:
- Macro FFT_SCHED_STALL_EN adds input STALL (1 bit).
- Defined: STALL=1 in ISSUE holds k, forces RD_En=0 and inserts a bubble in the write pipe. In-flight writes still drain, since the MAC has no enable. STALL is ignored in IDLE/DRAIN/FIN.
- Not defined: no STALL port; issue is never interrupted.

Test Plan:
- L=2, START pulse at t=0 -> 12 RD_En cycles with exact address/W8 schedule above; WR_En mirrors each 2 cycles later; DONE at t=19; BUSY t=1..18.
- START held high continuously -> exactly one run, DONE at t=19; new run begins t=21 (IDLE sampled at t=20).
- RST=0 asserted at t=8 (stage 1 issuing) -> all outputs 0 asynchronously, no DONE; START after release -> clean full run.
- MAC_LATENCY=1 -> each DRAIN 1 cycle, WR_En 1 cycle after RD_En, DONE at t=16.
- FFT_SCHED_STALL_EN, STALL=1 for 2 cycles at stage 0 k=2 -> RD_En gaps 2 cycles, k=2 reissued after, DONE at t=21, write order unchanged.
